// File: rtl/laser_hit_scorer.sv
// Scoring stage downstream of the LASER circle-placement block.
// Snoops the 40-point X/Y load stream, then on DONE latches both circle
// centres and counts how many stored points fall inside either circle,
// PTS_PER_CYC points per cycle.
// Optional feature: define SCORER_PER_CIRCLE_EN to add per-circle counts
// C1_CNT and C2_CNT (overlap points counted in both).
module laser_hit_scorer #(
  parameter int unsigned NPTS        = 40,
  parameter int unsigned PTS_PER_CYC = 4,
  parameter int unsigned RADIUS_SQ   = 16,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       X,
  input  logic [3:0]       Y,
  input  logic [3:0]       C1X,
  input  logic [3:0]       C1Y,
  input  logic [3:0]       C2X,
  input  logic [3:0]       C2Y,
  input  logic             DONE,
`ifdef SCORER_PER_CIRCLE_EN
  output logic [CNT_W-1:0] C1_CNT,
  output logic [CNT_W-1:0] C2_CNT,
`endif
  output logic [CNT_W-1:0] HIT_CNT,
  output logic             SCORE_VALID,
  output logic             BUSY
);

  localparam int unsigned IDX_W = $clog2(NPTS);
  localparam logic [IDX_W-1:0] LastLoad  = IDX_W'(NPTS - 1);
  localparam logic [IDX_W-1:0] LastScore = IDX_W'(NPTS - PTS_PER_CYC);
  localparam logic [IDX_W-1:0] IdxStep   = IDX_W'(PTS_PER_CYC);
  localparam logic [8:0]       RadSq     = 9'(RADIUS_SQ);

  typedef enum logic [1:0] {StLoad, StWait, StScore, StReport} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] acc_q;
  logic [3:0]       c1x_q, c1y_q, c2x_q, c2y_q;

  logic [3:0] x_buf_q [NPTS];
  logic [3:0] y_buf_q [NPTS];

  logic [IDX_W-1:0]       pidx [PTS_PER_CYC];
  logic [PTS_PER_CYC-1:0] in1, in2;
  logic [CNT_W-1:0]       cycle_hits;
`ifdef SCORER_PER_CIRCLE_EN
  logic [CNT_W-1:0]       c1_acc_q, c2_acc_q;
  logic [CNT_W-1:0]       cycle_c1, cycle_c2;
`endif

  // Full-precision squared distance: |a-b| stays unsigned, squares are 8 bits, sum 9 bits.
  function automatic logic [8:0] dist_sq(input logic [3:0] ax, input logic [3:0] ay,
                                         input logic [3:0] bx, input logic [3:0] by);
    logic [3:0] dx, dy;
    logic [7:0] dx_sq, dy_sq;
    dx    = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy    = (ay >= by) ? (ay - by) : (by - ay);
    dx_sq = {4'b0, dx} * {4'b0, dx};
    dy_sq = {4'b0, dy} * {4'b0, dy};
    return {1'b0, dx_sq} + {1'b0, dy_sq};
  endfunction

  // Evaluate the current group of points against the latched centres.
  always_comb begin
    in1        = '0;
    in2        = '0;
    cycle_hits = '0;
`ifdef SCORER_PER_CIRCLE_EN
    cycle_c1   = '0;
    cycle_c2   = '0;
`endif
    for (int i = 0; i < int'(PTS_PER_CYC); i++) begin
      pidx[i] = idx_q + IDX_W'(i);
      in1[i]  = dist_sq(x_buf_q[pidx[i]], y_buf_q[pidx[i]], c1x_q, c1y_q) <= RadSq;
      in2[i]  = dist_sq(x_buf_q[pidx[i]], y_buf_q[pidx[i]], c2x_q, c2y_q) <= RadSq;
      // A point inside both circles contributes one hit.
      cycle_hits = cycle_hits + CNT_W'(in1[i] | in2[i]);
`ifdef SCORER_PER_CIRCLE_EN
      cycle_c1   = cycle_c1 + CNT_W'(in1[i]);
      cycle_c2   = cycle_c2 + CNT_W'(in2[i]);
`endif
    end
  end

  // Point buffer capture; no reset needed since LOAD rewrites every entry before use.
  always_ff @(posedge CLK) begin
    if (!RST && (state_q == StLoad)) begin
      x_buf_q[idx_q] <= X;
      y_buf_q[idx_q] <= Y;
    end
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      acc_q       <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      HIT_CNT     <= '0;
      SCORE_VALID <= 1'b0;
      BUSY        <= 1'b0;
`ifdef SCORER_PER_CIRCLE_EN
      c1_acc_q    <= '0;
      c2_acc_q    <= '0;
      C1_CNT      <= '0;
      C2_CNT      <= '0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          if (idx_q == LastLoad) begin
            idx_q   <= '0;
            state_q <= StWait;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StWait: begin
          if (DONE) begin
            c1x_q    <= C1X;
            c1y_q    <= C1Y;
            c2x_q    <= C2X;
            c2y_q    <= C2Y;
            acc_q    <= '0;
`ifdef SCORER_PER_CIRCLE_EN
            c1_acc_q <= '0;
            c2_acc_q <= '0;
`endif
            idx_q    <= '0;
            BUSY     <= 1'b1;
            state_q  <= StScore;
          end
        end
        StScore: begin
          acc_q    <= acc_q + cycle_hits;
`ifdef SCORER_PER_CIRCLE_EN
          c1_acc_q <= c1_acc_q + cycle_c1;
          c2_acc_q <= c2_acc_q + cycle_c2;
`endif
          if (idx_q == LastScore) begin
            HIT_CNT     <= acc_q + cycle_hits;
`ifdef SCORER_PER_CIRCLE_EN
            C1_CNT      <= c1_acc_q + cycle_c1;
            C2_CNT      <= c2_acc_q + cycle_c2;
`endif
            SCORE_VALID <= 1'b1;
            BUSY        <= 1'b0;
            idx_q       <= '0;
            state_q     <= StReport;
          end else begin
            idx_q <= idx_q + IdxStep;
          end
        end
        StReport: begin
          // Terminal until RST.
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
